hazard_scoreboard: RTL and testbench



---
 rtl/hazard_scoreboard.sv | 131 +++++++++++++
 tb/tb_hazard_scoreboard.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// Hazard detection and ID-stage operand forwarding for the in-order MIPS pipeline.
// Define HAZARD_FORWARD_EN for forwarding; leave it undefined for legacy stall-on-any-match.
module hazard_scoreboard #(
    parameter int DATA_W         = 32,
    parameter int REG_AW         = 5,
    parameter int DEPTH          = 3,
    parameter int LOAD_READY     = 1,
    parameter int REDIRECT_STAGE = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    id_valid,
    input  logic [REG_AW-1:0]       id_rs,
    input  logic [REG_AW-1:0]       id_rt,
    input  logic                    id_rs_used,
    input  logic                    id_rt_used,
    input  logic                    id_we,
    input  logic [REG_AW-1:0]       id_dst,
    input  logic                    id_is_load,
    input  logic [DATA_W-1:0]       rf_rdata_a,
    input  logic [DATA_W-1:0]       rf_rdata_b,
    input  logic [DEPTH*DATA_W-1:0] stage_data,
    input  logic                    redirect,
    output logic                    stall,
    output logic                    bubble,
    output logic                    flush_id,
    output logic [DATA_W-1:0]       opnd_a,
    output logic [DATA_W-1:0]       opnd_b,
    output logic                    fwd_a_hit,
    output logic                    fwd_b_hit,
    output logic [31:0]             stall_cnt,
    output logic [31:0]             flush_cnt
);

    typedef struct packed {
        logic              v;
        logic              we;
        logic [REG_AW-1:0] dst;
        logic              ld;
    } slot_t;

    typedef struct packed {
        logic              found;
        logic              ready;
        logic [DATA_W-1:0] data;
    } lookup_t;

    slot_t   slots [DEPTH];
    lookup_t look_a, look_b;
    logic    haz_a, haz_b;

    // Scanning oldest to youngest lets the youngest (lowest slot) match overwrite older ones.
    function automatic lookup_t lookup(input logic [REG_AW-1:0] src, input logic used);
        lookup_t r;
        r = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (slots[k].v && slots[k].we && slots[k].dst == src && src != '0 && used) begin
                r.found = 1'b1;
                r.ready = !slots[k].ld || (k >= LOAD_READY);
                r.data  = stage_data[k*DATA_W +: DATA_W];
            end
        end
        return r;
    endfunction

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        look_a    = lookup(id_rs, id_rs_used);
        look_b    = lookup(id_rt, id_rt_used);
        opnd_a    = rf_rdata_a;
        opnd_b    = rf_rdata_b;
        fwd_a_hit = 1'b0;
        fwd_b_hit = 1'b0;
`ifdef HAZARD_FORWARD_EN
        haz_a = look_a.found && !look_a.ready;
        haz_b = look_b.found && !look_b.ready;
        if (look_a.found && look_a.ready) begin
            opnd_a    = look_a.data;
            fwd_a_hit = 1'b1;
        end
        if (look_b.found && look_b.ready) begin
            opnd_b    = look_b.data;
            fwd_b_hit = 1'b1;
        end
`else
        haz_a = look_a.found;
        haz_b = look_b.found;
`endif
        stall    = id_valid && (haz_a || haz_b) && !redirect;
        bubble   = stall || redirect;
        flush_id = redirect;
    end

`ifndef HAZARD_FORWARD_EN
    logic unused_fwd;
    assign unused_fwd = ^{look_a.ready, look_a.data, look_b.ready, look_b.data};
`endif

    // NOTE: slot valid bits are control state, so the whole scoreboard is reset, not just data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                slots[k] <= '0;
            end
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so the shift reads old slot values.
            if (bubble || !id_valid) begin
                slots[0] <= '0;
            end else begin
                slots[0] <= '{v: 1'b1, we: id_we, dst: id_dst, ld: id_is_load};
            end
            // Entries landing in 1..REDIRECT_STAGE are younger than the resolved branch.
            for (int k = 1; k < DEPTH; k++) begin
                if (redirect && k <= REDIRECT_STAGE) begin
                    slots[k] <= '0;
                end else begin
                    slots[k] <= slots[k-1];
                end
            end
            if (stall && stall_cnt != '1) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (redirect && flush_cnt != '1) begin
                flush_cnt <= flush_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed plan scenarios plus randomized traffic
// checked against an in-flight instruction list model; follows HAZARD_FORWARD_EN like the RTL.
module tb_hazard_scoreboard;

    localparam int DW  = 32;
    localparam int AW  = 5;
    localparam int DEP = 3;
    localparam int LR  = 1;
    localparam int RS  = 1;
`ifdef HAZARD_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            id_valid, id_rs_used, id_rt_used, id_we, id_is_load, redirect;
    logic [AW-1:0]   id_rs, id_rt, id_dst;
    logic [DW-1:0]   rf_rdata_a, rf_rdata_b;
    logic [DEP*DW-1:0] stage_data;
    logic            stall, bubble, flush_id, fwd_a_hit, fwd_b_hit;
    logic [DW-1:0]   opnd_a, opnd_b;
    logic [31:0]     stall_cnt, flush_cnt;

    hazard_scoreboard dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_we(id_we), .id_dst(id_dst),
        .id_is_load(id_is_load), .rf_rdata_a(rf_rdata_a), .rf_rdata_b(rf_rdata_b),
        .stage_data(stage_data), .redirect(redirect), .stall(stall), .bubble(bubble),
        .flush_id(flush_id), .opnd_a(opnd_a), .opnd_b(opnd_b), .fwd_a_hit(fwd_a_hit),
        .fwd_b_hit(fwd_b_hit), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int        stage;
        logic      we;
        logic [4:0] dst;
        logic      ld;
    } entry_t;

    entry_t inflight[$];
    int     vectors = 0;
    int     miscompares = 0;
    int     m_stalls = 0;
    int     m_flushes = 0;
    logic   last_stall = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Queue position of the youngest in-flight writer of src, or -1.
    function automatic int youngest(input logic [4:0] src, input logic used);
        int best = -1;
        foreach (inflight[i]) begin
            if (used && src != 0 && inflight[i].we && inflight[i].dst == src &&
                (best < 0 || inflight[i].stage < inflight[best].stage))
                best = i;
        end
        return best;
    endfunction

    task automatic expect_opnd(input int idx, input logic [31:0] rf, output logic haz,
                               output logic [31:0] val, output logic hit, output logic chk);
        int s;
        haz = 1'b0; val = rf; hit = 1'b0; chk = 1'b1;
        if (idx >= 0) begin
            s = inflight[idx].stage;
            if (!FWD) begin
                haz = 1'b1;
            end else if (!inflight[idx].ld || s >= LR) begin
                val = stage_data[s*DW +: DW];
                hit = 1'b1;
            end else begin
                haz = 1'b1;
                chk = 1'b0;
            end
        end
    endtask

    task automatic cycle(input logic v, input logic [4:0] rs, input logic rsu, input logic [4:0] rt,
                         input logic rtu, input logic we, input logic [4:0] dst, input logic ld,
                         input logic redir);
        logic haz_a, haz_b, e_ha, e_hb, chk_a, chk_b, e_stall, e_bubble;
        logic [31:0] e_a, e_b;
        entry_t nq[$];
        entry_t e;
        @(negedge clk);
        id_valid = v; id_rs = rs; id_rs_used = rsu; id_rt = rt; id_rt_used = rtu;
        id_we = we; id_dst = dst; id_is_load = ld; redirect = redir;
        rf_rdata_a = $urandom; rf_rdata_b = $urandom;
        stage_data = {$urandom, $urandom, $urandom};
        #1;
        expect_opnd(youngest(rs, rsu), rf_rdata_a, haz_a, e_a, e_ha, chk_a);
        expect_opnd(youngest(rt, rtu), rf_rdata_b, haz_b, e_b, e_hb, chk_b);
        e_stall  = v && (haz_a || haz_b) && !redir;
        e_bubble = e_stall || redir;
        check("stall", {31'd0, stall}, {31'd0, e_stall});
        check("bubble", {31'd0, bubble}, {31'd0, e_bubble});
        check("flush_id", {31'd0, flush_id}, {31'd0, redir});
        if (chk_a) begin
            check("opnd_a", opnd_a, e_a);
            check("fwd_a_hit", {31'd0, fwd_a_hit}, {31'd0, e_ha});
        end
        if (chk_b) begin
            check("opnd_b", opnd_b, e_b);
            check("fwd_b_hit", {31'd0, fwd_b_hit}, {31'd0, e_hb});
        end
        check("stall_cnt", stall_cnt, m_stalls);
        check("flush_cnt", flush_cnt, m_flushes);
        last_stall = e_stall;
        @(posedge clk);
        foreach (inflight[i]) begin
            e = inflight[i];
            if (!(redir && e.stage < RS)) begin
                e.stage++;
                if (e.stage < DEP) nq.push_back(e);
            end
        end
        if (v && !e_bubble) nq.push_back('{0, we, dst, ld});
        inflight = nq;
        if (e_stall) m_stalls++;
        if (redir) m_flushes++;
    endtask

    // Presents one instruction until it leaves ID; bounded so a stuck stall cannot hang.
    task automatic run_instr(input logic [4:0] rs, input logic rsu, input logic [4:0] rt,
                             input logic rtu, input logic we, input logic [4:0] dst,
                             input logic ld, output int stalls);
        stalls = 0;
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, rs, rsu, rt, rtu, we, dst, ld, 1'b0);
            if (!last_stall) break;
            stalls++;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    initial begin
        int s;
        int base;
        logic [4:0] r_rs, r_rt, r_dst;
        logic r_rsu, r_rtu, r_we, r_ld, r_v, r_redir;

        rst = 1'b1;
        id_valid = 1'b1; id_rs = 5'd1; id_rt = 5'd2; id_rs_used = 1'b1; id_rt_used = 1'b1;
        id_we = 1'b0; id_dst = 5'd0; id_is_load = 1'b0; redirect = 1'b0;
        rf_rdata_a = 32'h1234_5678; rf_rdata_b = 32'h9abc_def0; stage_data = '1;
        #2;
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_bubble", {31'd0, bubble}, 32'd0);
        check("rst_flush", {31'd0, flush_id}, 32'd0);
        check("rst_hit_a", {31'd0, fwd_a_hit}, 32'd0);
        check("rst_opnd_a", opnd_a, 32'h1234_5678);
        check("rst_opnd_b", opnd_b, 32'h9abc_def0);
        check("rst_stall_cnt", stall_cnt, 32'd0);
        check("rst_flush_cnt", flush_cnt, 32'd0);
        id_valid = 1'b0;
        #10 rst = 1'b0;

        // add $1,$2,$3 then sub $4,$1,$5
        run_instr(5'd2, 1'b1, 5'd3, 1'b1, 1'b1, 5'd1, 1'b0, s);
        check("add_stalls", s, 32'd0);
        run_instr(5'd1, 1'b1, 5'd5, 1'b1, 1'b1, 5'd4, 1'b0, s);
        check("alu_use_stalls", s, FWD ? 32'd0 : 32'd3);
        idle(DEP);

        // lw $1,0($0) then add $2,$1,$1
        base = m_stalls;
        run_instr(5'd0, 1'b1, 5'd0, 1'b0, 1'b1, 5'd1, 1'b1, s);
        run_instr(5'd1, 1'b1, 5'd1, 1'b1, 1'b1, 5'd2, 1'b0, s);
        check("load_use_stalls", s, FWD ? 32'd1 : 32'd3);
        check("load_use_cnt_delta", stall_cnt - base, FWD ? 32'd1 : 32'd3);
        idle(DEP);

        // write to $0, then reader of $0
        run_instr(5'd2, 1'b1, 5'd3, 1'b1, 1'b1, 5'd0, 1'b0, s);
        run_instr(5'd0, 1'b1, 5'd0, 1'b1, 1'b1, 5'd4, 1'b0, s);
        check("zero_reg_stalls", s, 32'd0);
        idle(DEP);

        // redirect with a load-use pending squashes the load
        run_instr(5'd0, 1'b1, 5'd0, 1'b0, 1'b1, 5'd1, 1'b1, s);
        cycle(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b1, 5'd2, 1'b0, 1'b1);
        run_instr(5'd1, 1'b1, 5'd0, 1'b0, 1'b1, 5'd2, 1'b0, s);
        check("post_redirect_stalls", s, 32'd0);
        check("flush_cnt_one", flush_cnt, 32'd1);
        idle(DEP);

        // three writers of $7 in flight, then reset
        run_instr(5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd7, 1'b0, s);
        run_instr(5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd7, 1'b0, s);
        run_instr(5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd7, 1'b1, s);
        @(negedge clk);
        id_valid = 1'b0; redirect = 1'b0;
        rst = 1'b1;
        #1;
        check("midrst_stall_cnt", stall_cnt, 32'd0);
        check("midrst_flush_cnt", flush_cnt, 32'd0);
        inflight.delete();
        m_stalls = 0;
        m_flushes = 0;
        #2 rst = 1'b0;
        run_instr(5'd7, 1'b1, 5'd7, 1'b1, 1'b1, 5'd8, 1'b0, s);
        check("after_rst_stalls", s, 32'd0);

        // randomized traffic over a small register set to provoke frequent hazards
        r_rs = 0; r_rt = 0; r_dst = 0; r_rsu = 0; r_rtu = 0; r_we = 0; r_ld = 0; r_v = 0;
        for (int n = 0; n < 400; n++) begin
            if (!last_stall) begin
                r_v   = ($urandom_range(0, 4) != 0);
                r_rs  = 5'($urandom_range(0, 3));
                r_rt  = 5'($urandom_range(0, 3));
                r_rsu = 1'($urandom);
                r_rtu = 1'($urandom);
                r_we  = 1'($urandom);
                r_dst = 5'($urandom_range(0, 3));
                r_ld  = r_we && ($urandom_range(0, 2) == 0);
            end
            r_redir = ($urandom_range(0, 9) == 0);
            cycle(r_v, r_rs, r_rsu, r_rt, r_rtu, r_we, r_dst, r_ld, r_redir);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
